// File: rtl/stream_cfg_queue.sv
// Configuration queue feeding the stream configuration dispatcher.
// The host fills a staging row word by word and commits it as a queue entry. Entry 0 is the active configuration.
module stream_cfg_queue #(
    parameter int CFGMEM_SIZE = 4,
    parameter int N_AGE       = 8,
    parameter int NBIT_WORD   = 32,
    parameter int LOG2_N_AGE  = $clog2(N_AGE),
    parameter int NBIT_CNT    = $clog2(CFGMEM_SIZE + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   flush_i,
    input  logic                                   wr_en_i,
    input  logic [LOG2_N_AGE-1:0]                  wr_age_i,
    input  logic [NBIT_WORD-1:0]                   wr_data_i,
    input  logic                                   commit_i,
    input  logic                                   cfg_next_i,
    output logic [CFGMEM_SIZE*N_AGE*NBIT_WORD-1:0] cfgmem_content_o,
    output logic [NBIT_CNT-1:0]                    count_o,
    output logic                                   empty_o,
    output logic                                   full_o,
    output logic                                   err_overflow_o,
    output logic                                   err_underflow_o
);

    typedef logic [N_AGE-1:0][NBIT_WORD-1:0] row_t;

    localparam logic [NBIT_CNT-1:0] FULL_CNT = NBIT_CNT'(CFGMEM_SIZE);

    logic [CFGMEM_SIZE-1:0][N_AGE-1:0][NBIT_WORD-1:0] entries_q, entries_d;
    row_t                staging_q, staging_d;
    row_t                push_row;
    logic [NBIT_CNT-1:0] count_q, count_d;
    logic [NBIT_CNT-1:0] push_idx;
    logic                err_ovf_q, err_ovf_d;
    logic                err_unf_q, err_unf_d;
    logic                is_empty, is_full;
    logic                do_push, do_pop;

    // A commit while full only lands when a pop frees a slot in the same cycle.
    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == FULL_CNT);
        do_pop   = cfg_next_i && !is_empty;
        do_push  = commit_i && (!is_full || cfg_next_i);
        push_row = staging_q;
        for (int a = 0; a < N_AGE; a++) begin
            if (wr_en_i && (wr_age_i == LOG2_N_AGE'(a))) begin
                push_row[a] = wr_data_i;
            end
        end
        push_idx = do_pop ? (count_q - 1'b1) : count_q;
    end

    always_comb begin
        entries_d = entries_q;
        staging_d = staging_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        if (flush_i) begin
            entries_d = '0;
            staging_d = '0;
            count_d   = '0;
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end else begin
            staging_d = commit_i ? '0 : push_row;
            // Zero-fill from the top keeps every slot at or above count all-zero.
            if (do_pop) begin
                for (int k = 0; k < CFGMEM_SIZE - 1; k++) begin
                    entries_d[k] = entries_q[k+1];
                end
                entries_d[CFGMEM_SIZE-1] = '0;
            end
            if (do_push) begin
                for (int k = 0; k < CFGMEM_SIZE; k++) begin
                    if (NBIT_CNT'(k) == push_idx) begin
                        entries_d[k] = push_row;
                    end
                end
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
            if (commit_i && is_full && !cfg_next_i) begin
                err_ovf_d = 1'b1;
            end
            if (cfg_next_i && is_empty) begin
                err_unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            entries_q <= '0;
            staging_q <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            staging_q <= staging_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign cfgmem_content_o = entries_q;
    assign count_o          = count_q;
    assign empty_o          = is_empty;
    assign full_o           = is_full;
    assign err_overflow_o   = err_ovf_q;
    assign err_underflow_o  = err_unf_q;

endmodule

// File: tb/tb_stream_cfg_queue.sv
// Directed bench for stream_cfg_queue: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_stream_cfg_queue;

    typedef logic [7:0][31:0]      row_t;
    typedef logic [3:0][7:0][31:0] mem_t;
    typedef struct packed {
        mem_t       content;
        logic [2:0] count;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic         clk_i;
    logic         rst_n_i;
    logic         flush_i;
    logic         wr_en_i;
    logic [2:0]   wr_age_i;
    logic [31:0]  wr_data_i;
    logic         commit_i;
    logic         cfg_next_i;
    logic [1023:0] cfgmem_content_o;
    logic [2:0]   count_o;
    logic         empty_o;
    logic         full_o;
    logic         err_overflow_o;
    logic         err_underflow_o;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    string name_q[$];

    stream_cfg_queue dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .flush_i          (flush_i),
        .wr_en_i          (wr_en_i),
        .wr_age_i         (wr_age_i),
        .wr_data_i        (wr_data_i),
        .commit_i         (commit_i),
        .cfg_next_i       (cfg_next_i),
        .cfgmem_content_o (cfgmem_content_o),
        .count_o          (count_o),
        .empty_o          (empty_o),
        .full_o           (full_o),
        .err_overflow_o   (err_overflow_o),
        .err_underflow_o  (err_underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic row_t one_word(input int age, input logic [31:0] w);
        row_t r;
        r = '0;
        r[age] = w;
        return r;
    endfunction

    function automatic exp_t mk(input row_t r0, input row_t r1, input row_t r2, input row_t r3,
                                input int cnt, input logic ovf, input logic unf);
        exp_t e;
        e.content[0] = r0;
        e.content[1] = r1;
        e.content[2] = r2;
        e.content[3] = r3;
        e.count      = 3'(cnt);
        e.ovf        = ovf;
        e.unf        = unf;
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t e);
        mem_t got;
        got = cfgmem_content_o;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== e.content[k]) begin
                errors++;
                $display("[TB] FAIL %s entry%0d: got %h, expected %h", name, k, got[k], e.content[k]);
            end
        end
        checks++;
        if (count_o !== e.count) begin
            errors++;
            $display("[TB] FAIL %s count_o: got %0d, expected %0d", name, count_o, e.count);
        end
        checks++;
        if (empty_o !== (e.count == 3'd0)) begin
            errors++;
            $display("[TB] FAIL %s empty_o: got %b, expected %b", name, empty_o, (e.count == 3'd0));
        end
        checks++;
        if (full_o !== (e.count == 3'd4)) begin
            errors++;
            $display("[TB] FAIL %s full_o: got %b, expected %b", name, full_o, (e.count == 3'd4));
        end
        checks++;
        if (err_overflow_o !== e.ovf) begin
            errors++;
            $display("[TB] FAIL %s err_overflow_o: got %b, expected %b", name, err_overflow_o, e.ovf);
        end
        checks++;
        if (err_underflow_o !== e.unf) begin
            errors++;
            $display("[TB] FAIL %s err_underflow_o: got %b, expected %b", name, err_underflow_o, e.unf);
        end
    endtask

    task automatic applyStimulus(input string name, input logic fl, input logic we, input int age,
                                 input logic [31:0] data, input logic cm, input logic nx, input exp_t e);
        @(negedge clk_i);
        flush_i    = fl;
        wr_en_i    = we;
        wr_age_i   = 3'(age);
        wr_data_i  = data;
        commit_i   = cm;
        cfg_next_i = nx;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk_i);
    endtask

    // Monitor: outputs are settled 2 time units after the edge that sampled the stimulus.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checkOutput(n, e);
            end
        end
    end

    initial begin
        row_t z, r_t2, r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h, r_i, r_j;
        exp_t zero_s;
        z    = '0;
        r_t2 = one_word(0, 32'h8000_0011);
        r_t2[3] = 32'h8000_0042;
        r_a  = one_word(1, 32'h8000_00A1);
        r_a[7] = 32'h8000_00A7;
        r_b  = one_word(2, 32'h8000_00B2);
        r_c  = one_word(4, 32'h8000_00C4);
        r_d  = one_word(5, 32'h8000_00D5);
        r_e  = one_word(6, 32'h8000_00E6);
        r_f  = one_word(0, 32'h8000_0077);
        r_g  = one_word(1, 32'h8000_0088);
        r_h  = one_word(2, 32'h8000_0099);
        r_i  = one_word(3, 32'h8000_00AA);
        r_j  = one_word(0, 32'h8000_00BB);
        zero_s = mk(z, z, z, z, 0, 1'b0, 1'b0);

        rst_n_i = 1'b0; flush_i = 1'b0; wr_en_i = 1'b0; wr_age_i = '0;
        wr_data_i = '0; commit_i = 1'b0; cfg_next_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_initial", zero_s);
        rst_n_i = 1'b1;

        applyStimulus("idle",          0, 0, 0, 32'h0,          0, 0, zero_s);
        applyStimulus("t2_wr_age0",    0, 1, 0, 32'h8000_0011,  0, 0, zero_s);
        applyStimulus("t2_wr_age3",    0, 1, 3, 32'h8000_0042,  0, 0, zero_s);
        applyStimulus("t2_commit",     0, 0, 0, 32'h0,          1, 0, mk(r_t2, z, z, z, 1, 0, 0));
        applyStimulus("t2_commit_clr", 0, 0, 0, 32'h0,          1, 0, mk(r_t2, z, z, z, 2, 0, 0));
        applyStimulus("flush_alone",   1, 0, 0, 32'h0,          0, 0, zero_s);

        applyStimulus("t3_wr_a1",      0, 1, 1, 32'h8000_00A1,  0, 0, zero_s);
        applyStimulus("t3_wr_a7",      0, 1, 7, 32'h8000_00A7,  0, 0, zero_s);
        applyStimulus("t3_commit_a",   0, 0, 0, 32'h0,          1, 0, mk(r_a, z, z, z, 1, 0, 0));
        applyStimulus("t3_wr_b",       0, 1, 2, 32'h8000_00B2,  0, 0, mk(r_a, z, z, z, 1, 0, 0));
        applyStimulus("t3_commit_b",   0, 0, 0, 32'h0,          1, 0, mk(r_a, r_b, z, z, 2, 0, 0));
        applyStimulus("t3_wr_c",       0, 1, 4, 32'h8000_00C4,  0, 0, mk(r_a, r_b, z, z, 2, 0, 0));
        applyStimulus("t3_commit_c",   0, 0, 0, 32'h0,          1, 0, mk(r_a, r_b, r_c, z, 3, 0, 0));
        applyStimulus("t3_bypass_d",   0, 1, 5, 32'h8000_00D5,  1, 0, mk(r_a, r_b, r_c, r_d, 4, 0, 0));
        applyStimulus("t3_wr_ff",      0, 1, 0, 32'h8000_00FF,  0, 0, mk(r_a, r_b, r_c, r_d, 4, 0, 0));
        applyStimulus("t3_overflow",   0, 0, 0, 32'h0,          1, 0, mk(r_a, r_b, r_c, r_d, 4, 1, 0));
        applyStimulus("t3_flush",      1, 0, 0, 32'h0,          0, 0, zero_s);

        applyStimulus("t4_wr_a1",      0, 1, 1, 32'h8000_00A1,  0, 0, zero_s);
        applyStimulus("t4_fill_a",     0, 1, 7, 32'h8000_00A7,  1, 0, mk(r_a, z, z, z, 1, 0, 0));
        applyStimulus("t4_fill_b",     0, 1, 2, 32'h8000_00B2,  1, 0, mk(r_a, r_b, z, z, 2, 0, 0));
        applyStimulus("t4_fill_c",     0, 1, 4, 32'h8000_00C4,  1, 0, mk(r_a, r_b, r_c, z, 3, 0, 0));
        applyStimulus("t4_fill_d",     0, 1, 5, 32'h8000_00D5,  1, 0, mk(r_a, r_b, r_c, r_d, 4, 0, 0));
        applyStimulus("t4_full_swap",  0, 1, 6, 32'h8000_00E6,  1, 1, mk(r_b, r_c, r_d, r_e, 4, 0, 0));

        applyStimulus("t5_pop3",       0, 0, 0, 32'h0,          0, 1, mk(r_c, r_d, r_e, z, 3, 0, 0));
        applyStimulus("t5_pop2",       0, 0, 0, 32'h0,          0, 1, mk(r_d, r_e, z, z, 2, 0, 0));
        applyStimulus("t5_pop1",       0, 0, 0, 32'h0,          0, 1, mk(r_e, z, z, z, 1, 0, 0));
        applyStimulus("t5_pop_last",   0, 0, 0, 32'h0,          0, 1, zero_s);
        applyStimulus("t5_underflow",  0, 0, 0, 32'h0,          0, 1, mk(z, z, z, z, 0, 0, 1));

        applyStimulus("empty_swap",    0, 1, 0, 32'h8000_0077,  1, 1, mk(r_f, z, z, z, 1, 0, 1));
        applyStimulus("push_g",        0, 1, 1, 32'h8000_0088,  1, 0, mk(r_f, r_g, z, z, 2, 0, 1));
        applyStimulus("partial_swap",  0, 1, 2, 32'h8000_0099,  1, 1, mk(r_g, r_h, z, z, 2, 0, 1));
        applyStimulus("push_i",        0, 1, 3, 32'h8000_00AA,  1, 0, mk(r_g, r_h, r_i, z, 3, 0, 1));
        applyStimulus("t6_flush_all",  1, 1, 4, 32'h8000_00CC,  1, 1, zero_s);
        applyStimulus("push_j",        0, 1, 0, 32'h8000_00BB,  1, 0, mk(r_j, z, z, z, 1, 0, 0));

        // Asynchronous reset in the middle of a cycle carrying a commit.
        @(negedge clk_i);
        flush_i = 1'b0; cfg_next_i = 1'b0;
        wr_en_i = 1'b1; wr_age_i = 3'd2; wr_data_i = 32'h8000_00DD; commit_i = 1'b1;
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("t1_async_reset", zero_s);
        @(negedge clk_i);
        wr_en_i = 1'b0; commit_i = 1'b0;
        rst_n_i = 1'b1;
        applyStimulus("after_reset",   0, 0, 0, 32'h0,          0, 0, zero_s);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk_i);
            #3;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
